load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: IDX_W, 8, word-index bits driven on mem_addr; mem_addr[31:IDX_W] SHALL be 0.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit can accept.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  zero-extend loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes significant.
- resp_valid  out  1  response pending.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned request (config-dependent).
- mem_read  out  1  to data memory read enable.
- mem_write  out  1  to data memory write enable.
- mem_addr  out  32  word index = {0, req_addr[IDX_W+1:2]}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data, valid combinationally while mem_read=1.

Function
REQ-003 SHALL use FSM states IDLE, READ, WRITE, RESP; one request in flight.
REQ-004 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; all req_* captured on handshake.
REQ-005 Load: IDLE -> READ (mem_read=1, word captured) -> RESP; resp_valid asserted 2 cycles after handshake.
REQ-006 Word store: IDLE -> WRITE (mem_write=1, mem_wdata=req_wdata) -> RESP; resp_valid 2 cycles after handshake.
REQ-007 Byte/half store: IDLE -> READ -> WRITE (read word with addressed lane(s) replaced) -> RESP; resp_valid 3 cycles after handshake.
REQ-008 Lane select: byte lane = addr[1:0], bits [8*k+7:8*k]; half lane = addr[1], bits [16*h+15:16*h]; little-endian.
REQ-009 Loads SHALL sign-extend from bit 7/15 unless req_unsigned=1; word loads unmodified.
REQ-010 mem_read and mem_write SHALL never be 1 in the same cycle; both 0 in IDLE and RESP.
REQ-011 RESP: resp_valid held stable with resp_rdata/resp_err constant until resp_ready=1; then IDLE next cycle; new request accepted no earlier than that IDLE cycle.
REQ-012 resp_valid & resp_ready in RESP with req_valid=1 SHALL NOT accept the request in that cycle.
REQ-013 mem_addr SHALL hold the captured word index through READ and WRITE.

Reset
REQ-014 rst=1 SHALL immediately force IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-015 rst mid-operation SHALL abandon the request with no memory write issued after reset assertion and no response.

Configuration
REQ-016 With MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE -> RESP directly (resp_valid 1 cycle after handshake), resp_err=1, resp_rdata=0, no memory access.
REQ-017 Without MISALIGN_TRAP_EN: resp_err SHALL be constant 0; misaligned addresses are aligned down (half clears addr[0], word clears addr[1:0]) and processed normally.

Verification
REQ-018 Memory word 3 = 0x8899AABB; load byte addr 0x0D signed -> mem_addr=3, resp_rdata=0xFFFFFFAA, resp_valid 2 cycles after handshake.
REQ-019 Same word; store byte 0x11 at addr 0x0E -> READ then WRITE with mem_wdata=0x8811AABB, resp_valid 3 cycles after handshake.
REQ-020 Load half unsigned addr 0x0E from 0x8899AABB -> resp_rdata=0x00008899; word store 0xDEADBEEF addr 0x10 -> single mem_write at mem_addr=4.
REQ-021 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, no memory strobes.
REQ-022 Word load addr 0x06: with MISALIGN_TRAP_EN -> resp_err=1, no mem_read; without -> mem_addr=1, resp_err=0.
REQ-023 rst asserted during READ of a sub-word store -> no mem_write ever issued, outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store front end for a word-wide data memory.
//   A request is accepted in IDLE, then runs READ and/or WRITE against
//   the memory and presents a held response in RESP. Byte and half stores
//   are done as read-modify-write of the containing word. Loads are
//   sign- or zero-extended. Lanes are little-endian.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned half/word requests skip memory, answer with resp_err=1
//     undefined : misaligned addresses are aligned down, resp_err is always 0
//
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_write, req_size,        store select, size (00 b, 01 h, 1x w),
//   req_unsigned                zero-extend loads
//   req_addr, req_wdata         byte address, store data (low bytes)
//   resp_valid / resp_ready     response handshake
//   resp_rdata, resp_err        extended load data (0 for stores), trap flag
//   mem_read, mem_write         memory strobes, never both
//   mem_addr                    word index, upper bits zero
//   mem_wdata, mem_rdata        full-word write data, combinational read data

module load_store_unit #(
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsuState;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} accessSize;

  lsuState          state, stateNext;
  logic             curWrite;
  logic             curUnsigned;
  accessSize        curSize;
  logic [1:0]       curLane;
  logic [IDX_W-1:0] curIdx;
  logic [31:0]      wordBuf;   // store data, later the merged word for sub-word stores
  logic [31:0]      respData;
  logic             respErr;

  accessSize        reqSize;
  logic [1:0]       reqLane;
  logic             trapReq;
  logic             reqFire;

  // Only the word-index bits reach the memory.
  logic             unusedAddrBits;
  assign unusedAddrBits = ^req_addr[31:IDX_W+2];

  // Pick the addressed lane(s) out of a word and extend to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [31:0] word, input accessSize size,
                                             input logic [1:0] lane, input logic zeroExt);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: extendLoad = zeroExt ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: extendLoad = zeroExt ? {16'b0, h} : {{16{h[15]}}, h};
      default: extendLoad = word;
    endcase
  endfunction

  // Replace the addressed lane(s) of an existing word with the low store bytes.
  function automatic logic [31:0] mergeLanes(input logic [31:0] word, input logic [31:0] data,
                                             input accessSize size, input logic [1:0] lane);
    mergeLanes = word;
    case (size)
      SZ_BYTE: mergeLanes[{lane, 3'b000} +: 8]    = data[7:0];
      SZ_HALF: mergeLanes[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: mergeLanes = data;
    endcase
  endfunction

  // Request decode: size 11 behaves as a word; misaligned lanes align down.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    reqSize = SZ_WORD;
    reqLane = 2'b00;
    if (req_size == 2'b00)      reqSize = SZ_BYTE;
    else if (req_size == 2'b01) reqSize = SZ_HALF;
    case (reqSize)
      SZ_BYTE: reqLane = req_addr[1:0];
      SZ_HALF: reqLane = {req_addr[1], 1'b0};
      default: reqLane = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trapReq = ((reqSize == SZ_HALF) && req_addr[0]) ||
                   ((reqSize == SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          respErr <= 1'b0;
    else if (reqFire) respErr <= trapReq;
  end
`else
  assign trapReq = 1'b0;
  assign respErr = 1'b0;
`endif

  assign reqFire = req_valid && (state == IDLE);

  // State register. Reset is asynchronous, so strobes drop the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and all decoded outputs.
  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (trapReq)                             stateNext = RESP;
          else if (req_write && reqSize == SZ_WORD) stateNext = WRITE;
          else                                     stateNext = READ;
        end
      end
      READ: begin
        mem_read                = 1'b1;
        mem_addr[IDX_W-1:0]     = curIdx;
        stateNext               = curWrite ? WRITE : RESP;
      end
      WRITE: begin
        mem_write               = 1'b1;
        mem_addr[IDX_W-1:0]     = curIdx;
        mem_wdata               = wordBuf;
        stateNext               = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = respData;
        resp_err   = respErr;
        if (resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request capture and the READ-cycle datapath (load extend or store merge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curWrite    <= 1'b0;
      curUnsigned <= 1'b0;
      curSize     <= SZ_BYTE;
      curLane     <= 2'b00;
      curIdx      <= '0;
      wordBuf     <= '0;
      respData    <= '0;
    end else begin
      if (reqFire) begin
        curWrite    <= req_write;
        curUnsigned <= req_unsigned;
        curSize     <= reqSize;
        curLane     <= reqLane;
        curIdx      <= req_addr[IDX_W+1:2];
        wordBuf     <= req_wdata;
        respData    <= '0;
      end
      if (state == READ) begin
        if (curWrite) wordBuf  <= mergeLanes(mem_rdata, wordBuf, curSize, curLane);
        else          respData <= extendLoad(mem_rdata, curSize, curLane, curUnsigned);
      end
    end
  end

endmodule
